spi_master_arbiter: RTL
=======================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, bits per frame; NUM_REQ, 4, number of requesters (2..8); CLK_DIV, 4, clk cycles per SCLK half-period (>=1); MSB_FIRST, 1, shift order (1 = MSB first).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- req  in  NUM_REQ  per-requester transfer request, level.
- req_data  in  NUM_REQ*DATA_WIDTH  TX word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- cpol, cpha  in  1 each  SPI mode, global.
- gnt  out  NUM_REQ  one-hot grant.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rx_data  out  DATA_WIDTH  last received word.
- busy  out  1  transfer in progress.
- sclk  out  1  SPI clock.
- cs_n  out  NUM_REQ  per-requester active-low chip select.
- mosi  out  1  serial out.
- miso  in  1  serial in.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, XFER, HOLD, DONE; all outputs SHALL be registered.
REQ-005 IDLE: with any req bit set, the FSM SHALL pick winner w round-robin, starting the search at last_grant+1 modulo NUM_REQ, and enter SETUP on the next cycle.
REQ-006 The SETUP entry cycle SHALL:
- set gnt[w]=1, cs_n[w]=0, busy=1;
- latch req_data slice w, cpol and cpha;
- update last_grant=w.
REQ-007 SETUP SHALL last CLK_DIV cycles with sclk=cpol; for cpha=0, mosi SHALL present the first bit (MSB if MSB_FIRST, else LSB) from SETUP entry.
REQ-008 XFER SHALL consist of 2*DATA_WIDTH half-periods of CLK_DIV cycles each, with sclk toggling at the start of each half-period. Odd toggles are leading edges, even toggles are trailing edges.
REQ-009 For cpha=0, miso SHALL be sampled at each leading edge and mosi advanced at each trailing edge except the last.
REQ-010 For cpha=1, mosi SHALL be advanced at each leading edge and miso sampled at each trailing edge.
REQ-011 Sampling SHALL capture the miso value present in the clk cycle in which sclk is updated to the sampling edge.
REQ-012 Received bits SHALL shift into the RX register in the order set by MSB_FIRST.
REQ-013 After the last half-period, sclk SHALL equal the latched cpol, and HOLD SHALL last CLK_DIV cycles with cs_n[w] still low.
REQ-014 DONE SHALL last exactly one cycle with:
- cs_n all 1, gnt=0, busy=0;
- done[w]=1;
- rx_data updated to the received word.
The FSM SHALL then return to IDLE.
REQ-015 Latency from the SETUP entry cycle to the DONE cycle SHALL be CLK_DIV*(2*DATA_WIDTH+2) cycles (72 at defaults).
REQ-016 Deassertion of req[w] mid-transfer SHALL be ignored; the transfer SHALL complete and done[w] SHALL pulse.
REQ-017 Changes to req_data, cpol or cpha after SETUP entry SHALL NOT affect the current transfer.
REQ-018 At most one gnt bit and at most one cs_n bit SHALL be active at any time.
REQ-019 Between back-to-back transfers, all cs_n SHALL be high for at least 2 cycles (DONE + IDLE).
REQ-020 In IDLE, sclk SHALL follow cpol with one-cycle latency and mosi SHALL be 0.
REQ-021 Requests arriving during a transfer SHALL wait; no request SHALL be dropped while held.
REQ-022 The round-robin scheme SHALL guarantee that a held request is served within NUM_REQ transfers.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately force:
- gnt=0, done=0, busy=0;
- rx_data=0, sclk=0, mosi=0;
- cs_n all 1;
- state=IDLE, last_grant=NUM_REQ-1.
REQ-024 A reset mid-transfer SHALL abort without a done pulse and without updating rx_data; operation SHALL resume on the first clk edge after release.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Mode 0, defaults: req[0] with data 0xA5 and a slave returning 0x3C -> mosi shows 1010_0101 MSB-first on leading edges; done[0] 72 cycles after SETUP entry; rx_data=0x3C.
- Modes 1, 2, 3 with 0x81/0x7E -> correct edge alignment; sclk idles at cpol; rx_data=0x7E in each mode.
- req=4'b1111 held through 4 transfers -> grant order 0,1,2,3, then 0; never two cs_n low at once; cs_n high >=2 cycles between frames.
- req[2] dropped mid-XFER -> frame completes and done[2] pulses; req[1] raised mid-transfer -> served next.
- rst_n pulsed low mid-XFER -> all cs_n high, sclk 0, busy 0 in the same cycle; no done pulse; a subsequent req[0] is served first.
- MSB_FIRST=0, CLK_DIV=1, 0x01 -> first mosi bit is 1; done 18 cycles after SETUP entry.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Purpose: round-robin arbiter that gives NUM_REQ requesters turns on one SPI master (modes 0-3).
// Latency: DONE comes CLK_DIV*(2*DATA_WIDTH+2) cycles after SETUP entry; the next SETUP can start two cycles after DONE.
// Backpressure: req is a level. A requester waits until it is granted, and the current frame always runs to completion.
// Ports: clk/rst_n; req, req_data (one DATA_WIDTH slice per requester), cpol/cpha -> gnt, done, rx_data, busy;
//        SPI side: sclk, cs_n (one per requester), mosi, miso.
module spi_master_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                            cpol,
    input  logic                            cpha,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            busy,
    output logic                            sclk,
    output logic [NUM_REQ-1:0]              cs_n,
    output logic                            mosi,
    input  logic                            miso
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HP_LAST = HW'(2 * DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [HW-1:0]           hp_q, hp_d;
    logic [LW-1:0]           last_q, last_d;
    logic [LW-1:0]           own_q, own_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      cs_n_q, cs_n_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;

    logic                    win_found;
    logic [LW-1:0]           win_idx;
    logic [DATA_WIDTH-1:0]   word;
    logic [DATA_WIDTH-1:0]   ord;
    logic                    tgl;
    logic                    lead;
    logic [HW-1:0]           hp_n;

    function automatic logic [DATA_WIDTH-1:0] rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
        return r;
    endfunction

    // Registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hp_q      <= '0;
            last_q    <= LW'(NUM_REQ - 1);
            own_q     <= '0;
            gnt_q     <= '0;
            cs_n_q    <= '1;
            done_q    <= '0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            rx_data_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            last_q    <= last_d;
            own_q     <= own_d;
            gnt_q     <= gnt_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            rx_data_q <= rx_data_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
        end
    end

    // Next state and registered outputs
    always_comb begin
        int idx;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        last_d    = last_q;
        own_d     = own_q;
        gnt_d     = gnt_q;
        cs_n_d    = cs_n_q;
        done_d    = '0;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        rx_data_d = rx_data_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        win_found = 1'b0;
        win_idx   = '0;
        word      = '0;
        ord       = '0;
        tgl       = 1'b0;
        lead      = 1'b0;
        hp_n      = hp_q + HW'(1);
        idx       = 0;

        // Round-robin search that starts just after the last owner
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = LW'(idx);
            end
        end

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (win_found) begin
                    state_d         = S_SETUP;
                    own_d           = win_idx;
                    last_d          = win_idx;
                    gnt_d           = '0;
                    gnt_d[win_idx]  = 1'b1;
                    cs_n_d          = '1;
                    cs_n_d[win_idx] = 1'b0;
                    busy_d          = 1'b1;
                    cpol_d          = cpol;
                    cpha_d          = cpha;
                    cnt_d           = CNT_MAX;
                    hp_d            = '0;
                    rx_d            = '0;
                    word            = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    // Shift internally MSB-first; for LSB-first the word is reversed once here
                    ord             = (MSB_FIRST != 0) ? word : rev(word);
                    if (!cpha) begin
                        // cpha=0: the first bit has to be on mosi before the first leading edge
                        mosi_d = ord[DATA_WIDTH-1];
                        tx_d   = {ord[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        tx_d   = ord;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_XFER;
                    cnt_d   = CNT_MAX;
                    tgl     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_XFER: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (hp_q == HP_LAST) state_d = S_HOLD;
                    else                 tgl     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d       = S_DONE;
                    cs_n_d        = '1;
                    gnt_d         = '0;
                    busy_d        = 1'b0;
                    done_d[own_q] = 1'b1;
                    rx_data_d     = (MSB_FIRST != 0) ? rx_q : rev(rx_q);
                    mosi_d        = 1'b0;
                    sclk_d        = cpol_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Edge actions happen on the same clk edge that registers the sclk toggle,
        // so miso is captured from the cycle just before sclk visibly moves.
        if (tgl) begin
            sclk_d = ~sclk_q;
            hp_d   = hp_n;
            lead   = hp_n[0];
            if (lead ^ cpha_q) begin
                rx_d = {rx_q[DATA_WIDTH-2:0], miso};
            end
            if (cpha_q ? lead : (!lead && hp_n != HP_LAST)) begin
                mosi_d = tx_q[DATA_WIDTH-1];
                tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule
